// File: rtl/mem_access_unit.sv
// Load/store adapter for RAM port 2: byte/half/word at any alignment, splits word-crossing accesses.
// Latency req->valid: 2 cycles (1 RAM access), 3 cycles (split), 1 cycle (error); ready=0 while busy, req not queued.
module mem_access_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] ram_a,
  output logic [31:0] ram_di,
  output logic [3:0]  ram_m,
  output logic        ram_we,
  input  logic [31:0] ram_do
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] lo_buf;
  logic [31:0] hi_buf;

  function automatic logic [3:0] byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    byte_mask = 4'b0001;
      2'd1:    byte_mask = 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  // Request-side decode, used only to pick the state leaving IDLE.
  logic [7:0] in_lanes;
  logic       in_split;
  logic       in_err;
  assign in_lanes = {4'b0000, byte_mask(size)} << addr[1:0];
  assign in_split = |in_lanes[7:4];
  assign in_err   = (size == 2'd3) || (in_split && !SPLIT_EN);

  logic [7:0]  lanes;
  logic        split;
  logic [31:0] word_a;
  logic [63:0] wide_wd;
  logic [63:0] wide_rd;
  logic [31:0] load_ext;
  assign lanes   = {4'b0000, byte_mask(r_size)} << r_addr[1:0];
  assign split   = |lanes[7:4];
  assign word_a  = {r_addr[31:2], 2'b00};
  // Low half feeds the first word, high half carries the bytes spilling into the next word.
  assign wide_wd = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
  assign wide_rd = {hi_buf, lo_buf} >> {r_addr[1:0], 3'b000};

  always_comb begin
    load_ext = 32'h0;
    case (r_size)
      2'd0:    load_ext = {{24{wide_rd[7]  & ~r_uns}}, wide_rd[7:0]};
      2'd1:    load_ext = {{16{wide_rd[15] & ~r_uns}}, wide_rd[15:0]};
      default: load_ext = wide_rd[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      lo_buf  <= 32'h0;
      hi_buf  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        r_we    <= we;
        r_size  <= size;
        r_uns   <= uns;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_err   <= in_err;
      end
      if (state == ACC0 && !r_we) lo_buf <= ram_do;
      if (state == ACC1 && !r_we) hi_buf <= ram_do;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    valid     = 1'b0;
    err       = 1'b0;
    rdata     = 32'h0;
    ram_a     = 32'h0;
    ram_di    = 32'h0;
    ram_m     = 4'h0;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) state_nxt = in_err ? RESP : ACC0;
      end
      ACC0: begin
        ram_a     = word_a;
        ram_m     = lanes[3:0];
        ram_di    = wide_wd[31:0];
        ram_we    = r_we;
        state_nxt = split ? ACC1 : RESP;
      end
      ACC1: begin
        ram_a     = word_a + 32'd4;
        ram_m     = lanes[7:4];
        ram_di    = wide_wd[63:32];
        ram_we    = r_we;
        state_nxt = RESP;
      end
      RESP: begin
        valid     = 1'b1;
        err       = r_err;
        if (!r_we && !r_err) rdata = load_ext;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand sequences for split, wrap, busy, error and reset cases.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, valid, err, ram_we;
  logic [31:0] rdata, ram_a, ram_di, ram_do;
  logic [3:0]  ram_m;

  logic        n_req, n_we, n_uns;
  logic [1:0]  n_size;
  logic [31:0] n_addr, n_wdata;
  logic        n_ready, n_valid, n_err, n_ram_we;
  logic [31:0] n_rdata, n_ram_a, n_ram_di;
  logic [3:0]  n_ram_m;

  always #5 clk = ~clk;

  mem_access_unit #(.SPLIT_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .valid(valid), .rdata(rdata),
    .err(err), .ram_a(ram_a), .ram_di(ram_di), .ram_m(ram_m), .ram_we(ram_we),
    .ram_do(ram_do)
  );

  mem_access_unit #(.SPLIT_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(n_req), .we(n_we), .size(n_size), .uns(n_uns),
    .addr(n_addr), .wdata(n_wdata), .ready(n_ready), .valid(n_valid), .rdata(n_rdata),
    .err(n_err), .ram_a(n_ram_a), .ram_di(n_ram_di), .ram_m(n_ram_m), .ram_we(n_ram_we),
    .ram_do(32'h0)
  );

  // 16-word RAM model; address bits above [5:2] alias, so 0xFFFFFFFC hits word 15.
  logic [31:0] mem [16];
  logic        preload;
  assign ram_do = mem[ram_a[5:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1]  <= 32'h80FF7F01;
      mem[15] <= 32'h5A000000;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_m[b]) mem[ram_a[5:2]][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] snap_a  [4];
  logic [3:0]  snap_m  [4];
  logic [31:0] snap_di [4];
  logic        snap_we [4];
  int          nsnap;
  logic        we_seen;

  // Issue one request from IDLE, record RAM-side activity, return completion and latency in cycles.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; lat = 1; nsnap = 0; we_seen = 1'b0;
    while (!valid && lat < 8) begin
      if (nsnap < 4) begin
        snap_a[nsnap] = ram_a; snap_m[nsnap] = ram_m;
        snap_di[nsnap] = ram_di; snap_we[nsnap] = ram_we;
        nsnap++;
      end
      we_seen |= ram_we;
      @(posedge clk); #1;
      lat++;
    end
    if (!valid) begin
      total++; bad++;
      $display("FAIL timeout: no valid within %0d cycles", lat);
    end
    rd = rdata; e = err; we_seen |= ram_we;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          vcnt;
    logic [31:0] vrd;
    logic        verr;

    rst_n = 1'b0; preload = 1'b1;
    req = 0; we = 0; uns = 0; size = 0; addr = 0; wdata = 0;
    n_req = 0; n_we = 0; n_uns = 0; n_size = 0; n_addr = 0; n_wdata = 0;
    @(posedge clk); #1;
    check("rst ready",  {31'h0, ready},  32'h1);
    check("rst valid",  {31'h0, valid},  32'h0);
    check("rst err",    {31'h0, err},    32'h0);
    check("rst rdata",  rdata,           32'h0);
    check("rst ram_we", {31'h0, ram_we}, 32'h0);
    check("rst ram_m",  {28'h0, ram_m},  32'h0);
    check("rst ram_a",  ram_a,           32'h0);
    check("rst ram_di", ram_di,          32'h0);
    @(posedge clk); #1;
    preload = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store: one full-mask write.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, rd, e, lat);
    check("sw8 lat",   lat, 2);
    check("sw8 ram_a", snap_a[0], 32'h8);
    check("sw8 ram_m", {28'h0, snap_m[0]}, 32'hF);
    check("sw8 ram_di", snap_di[0], 32'h11223344);
    check("sw8 ram_we", {31'h0, snap_we[0]}, 32'h1);

    //               we    size  uns   addr   wdata          rdata          err   lat
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,         32'h11223344, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h6, 32'h0,         32'hFFFFFFFF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h7, 32'h0,         32'h00000080, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h5, 32'h0,         32'h0000FF7F, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h5, 32'h0,         32'hFFFFFF7F, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h4, 32'h0,         32'h00000001, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h6, 32'h0,         32'hFFFF80FF, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFFFFEE,  32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,         32'h1122EE44, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'hA, 32'h1234BEEF,  32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,         32'hBEEFEE44, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'hA, 32'h0,         32'h0000BEEF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h8, 32'h0,         32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h8, 32'hDEADBEEF,  32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h80FF7F01, 1'b0, 2});

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].exp_err) check($sformatf("v%0d no write", i), {31'h0, we_seen}, 32'h0);
    end

    // Split word store across words 0 and 1.
    do_req(1'b1, 2'd2, 1'b0, 32'h3, 32'hAABBCCDD, rd, e, lat);
    check("ssw lat", lat, 3);
    check("ssw a0",  snap_a[0], 32'h0);
    check("ssw m0",  {28'h0, snap_m[0]}, 32'h8);
    check("ssw di0", snap_di[0], 32'hDD000000);
    check("ssw a1",  snap_a[1], 32'h4);
    check("ssw m1",  {28'h0, snap_m[1]}, 32'h7);
    check("ssw di1", snap_di[1], 32'h00AABBCC);
    check("ssw we1", {31'h0, snap_we[1]}, 32'h1);
    do_req(1'b0, 2'd2, 1'b0, 32'h3, 32'h0, rd, e, lat);
    check("slw rdata", rd, 32'hAABBCCDD);
    check("slw lat", lat, 3);
    check("slw we0", {31'h0, snap_we[0]}, 32'h0);
    check("slw m0",  {28'h0, snap_m[0]}, 32'h8);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, e, lat);
    check("w1 after split", rd, 32'h80AABBCC);

    // Halfword at the top of the address space wraps to word 0.
    do_req(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, rd, e, lat);
    check("wrap a0", snap_a[0], 32'hFFFFFFFC);
    check("wrap m0", {28'h0, snap_m[0]}, 32'h8);
    check("wrap a1", snap_a[1], 32'h0);
    check("wrap m1", {28'h0, snap_m[1]}, 32'h1);
    check("wrap rdata", rd, 32'h0000005A);
    check("wrap lat", lat, 3);

    // A request raised while busy must be dropped, not queued.
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h3; req = 1'b1;
    @(posedge clk); #1;
    size = 2'd3;
    @(posedge clk); #1;
    req = 1'b0;
    vcnt = 0; vrd = 32'h0; verr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (valid) begin vcnt++; vrd = rdata; verr = err; end
      @(posedge clk); #1;
    end
    check("busy valids", vcnt, 1);
    check("busy rdata", vrd, 32'hAABBCCDD);
    check("busy err", {31'h0, verr}, 32'h0);

    // Reset during the first access of a split store.
    we = 1'b1; size = 2'd2; addr = 32'h3; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid ram_we pre", {31'h0, ram_we}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("mid ram_we", {31'h0, ram_we}, 32'h0);
    check("mid ram_m", {28'h0, ram_m}, 32'h0);
    check("mid valid", {31'h0, valid}, 32'h0);
    check("mid ready", {31'h0, ready}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post valid", {31'h0, valid}, 32'h0);
    check("post ready", {31'h0, ready}, 32'h1);
    @(posedge clk); #1;
    check("post w0", mem[0], 32'hDD000000);
    check("post w1", mem[1], 32'h80AABBCC);

    // Non-splitting instance: crossing store errors out, aligned-in-word half still writes.
    n_we = 1'b1; n_size = 2'd2; n_addr = 32'h2; n_wdata = 32'h55667788; n_req = 1'b1;
    #1;
    check("ns idle we", {31'h0, n_ram_we}, 32'h0);
    @(posedge clk); #1;
    n_req = 1'b0;
    check("ns valid", {31'h0, n_valid}, 32'h1);
    check("ns err", {31'h0, n_err}, 32'h1);
    check("ns ram_we", {31'h0, n_ram_we}, 32'h0);
    @(posedge clk); #1;
    n_size = 2'd1; n_req = 1'b1;
    @(posedge clk); #1;
    n_req = 1'b0;
    check("ns sh we", {31'h0, n_ram_we}, 32'h1);
    check("ns sh m", {28'h0, n_ram_m}, 32'hC);
    check("ns sh di", n_ram_di, 32'h77880000);
    @(posedge clk); #1;
    check("ns sh valid", {31'h0, n_valid}, 32'h1);
    check("ns sh err", {31'h0, n_err}, 32'h0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
